core_wb_data_bridge: RTL

- Parametrised bridge from a CPU core's native load/store strobes to a registered Wishbone B4 classic master port. It sits between a core and the Controller data-memory bus.
- Adds byte-select generation, lane alignment, and sign-extension on loads.
- Adds misalignment detection, slave error propagation, and a timeout watchdog.
- Provides an explicit response handshake, so a core can stall on slow memory.

---
 rtl/processorci_bus_pkg.sv | 12 +
 rtl/core_wb_data_bridge_if.sv | 25 ++
 rtl/wb_lane_align.sv | 43 ++++
 rtl/core_wb_data_bridge.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/processorci_bus_pkg.sv
// Shared types for the core-to-Wishbone data bridge: access sizes, FSM states, size decode.
package processorci_bus_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

   typedef enum logic [1:0] {IDLE, BUS, RESP} bridge_state_e;

   function automatic int unsigned size_bytes(input size_e size);
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/core_wb_data_bridge_if.sv
// Wishbone B4 classic bus between the bridge (master) and data memory (slave).
interface core_wb_data_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      wb_cyc;
   logic                      wb_stb;
   logic                      wb_we;
   logic [ADDR_WIDTH-1:0]     wb_adr;
   logic [DATA_WIDTH-1:0]     wb_dat_o;
   logic [DATA_WIDTH/8-1:0]   wb_sel;
   logic [DATA_WIDTH-1:0]     wb_dat_i;
   logic                      wb_ack;
   logic                      wb_err;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
      input  wb_dat_i, wb_ack, wb_err
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
      output wb_dat_i, wb_ack, wb_err
   );
endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering: select/data shift for stores, extract and sign/zero-extend for loads.
module wb_lane_align
   import processorci_bus_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH = 32,
   localparam int unsigned SEL_W      = DATA_WIDTH / 8,
   localparam int unsigned OFF_W      = $clog2(SEL_W)
) (
   input  logic [OFF_W-1:0]      off,
   input  size_e                 size,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [SEL_W-1:0]      sel,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] rdata
);

   int unsigned           nbytes;
   logic [SEL_W-1:0]      sel_base;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic                  sign;

   always_comb begin
      nbytes   = size_bytes(size);
      sel_base = '0;
      for (int unsigned i = 0; i < SEL_W; i++) begin
         if (i < nbytes) sel_base[i] = 1'b1;
      end
      mask = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (i < 8 * nbytes) mask[i] = 1'b1;
      end
      sel     = sel_base << off;
      dat_o   = wdata << {off, 3'b000};
      shifted = dat_i >> {off, 3'b000};
      // mask & ~(mask >> 1) isolates the top bit of the accessed field
      sign    = is_signed & (|(shifted & mask & ~(mask >> 1)));
      rdata   = (shifted & mask) | ({DATA_WIDTH{sign}} & ~mask);
   end

endmodule

// File: rtl/core_wb_data_bridge.sv
// Core load/store strobes to a registered Wishbone B4 classic master, with alignment,
// error propagation and a bus watchdog.
module core_wb_data_bridge
   import processorci_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          READ_ONLY      = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_rd,
   input  logic                   req_wr,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [1:0]             req_size,
   input  logic                   req_signed,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   rsp_err,
   output logic                   rsp_timeout,
   output logic                   busy,
   core_wb_data_bridge_if.master  wb
);

   localparam int unsigned SEL_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(SEL_W);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   bridge_state_e         state;
   logic [OFF_W-1:0]      off_q;
   size_e                 size_q;
   logic                  signed_q;
   logic [CNT_W-1:0]      timeout_cnt;

   logic                  req_any;
   logic [ADDR_WIDTH-1:0] size_mask;
   logic                  misaligned;
   logic                  reject;
   logic                  timeout_hit;
   logic [OFF_W-1:0]      align_off;
   size_e                 align_size;
   logic                  align_signed;
   logic [SEL_W-1:0]      sel_next;
   logic [DATA_WIDTH-1:0] dat_next;
   logic [DATA_WIDTH-1:0] rdata_next;

   assign req_any     = req_rd | req_wr;
   assign size_mask   = ADDR_WIDTH'(size_bytes(size_e'(req_size)) - 1);
   assign misaligned  = ((DATA_WIDTH == 32) && (req_size == 2'd3)) ||
                        ((req_addr & size_mask) != '0);
   assign reject      = (req_rd & req_wr) | (req_wr & READ_ONLY) | misaligned;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(timeout_cnt) + 32'd1) == TIMEOUT_CYCLES);
   assign busy        = (state == BUS) | ((state == IDLE) & req_any);

   // Live request drives the aligner at accept; latched fields drive it during the bus phase
   assign align_off    = (state == IDLE) ? req_addr[OFF_W-1:0] : off_q;
   assign align_size   = (state == IDLE) ? size_e'(req_size) : size_q;
   assign align_signed = (state == IDLE) ? req_signed : signed_q;

   wb_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .off       (align_off),
      .size      (align_size),
      .is_signed (align_signed),
      .wdata     (req_wdata),
      .sel       (sel_next),
      .dat_o     (dat_next),
      .dat_i     (wb.wb_dat_i),
      .rdata     (rdata_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         off_q       <= '0;
         size_q      <= SZ_B;
         signed_q    <= 1'b0;
         timeout_cnt <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         wb.wb_cyc   <= 1'b0;
         wb.wb_stb   <= 1'b0;
         wb.wb_we    <= 1'b0;
         wb.wb_adr   <= '0;
         wb.wb_dat_o <= '0;
         wb.wb_sel   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_any && reject) begin
                  state       <= RESP;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= '0;
               end else if (req_any) begin
                  state       <= BUS;
                  wb.wb_cyc   <= 1'b1;
                  wb.wb_stb   <= 1'b1;
                  wb.wb_we    <= req_wr;
                  wb.wb_adr   <= req_addr & ~ADDR_WIDTH'(SEL_W - 1);
                  wb.wb_sel   <= sel_next;
                  wb.wb_dat_o <= dat_next;
                  off_q       <= req_addr[OFF_W-1:0];
                  size_q      <= size_e'(req_size);
                  signed_q    <= req_signed;
                  timeout_cnt <= '0;
               end
            end
            BUS: begin
               if (wb.wb_err || wb.wb_ack || timeout_hit) begin
                  state       <= RESP;
                  wb.wb_cyc   <= 1'b0;
                  wb.wb_stb   <= 1'b0;
                  rsp_valid   <= 1'b1;
                  // err outranks ack; neither means the watchdog fired
                  rsp_err     <= wb.wb_err | ~wb.wb_ack;
                  rsp_timeout <= ~wb.wb_err & ~wb.wb_ack;
                  rsp_rdata   <= (wb.wb_ack && !wb.wb_err) ? rdata_next : '0;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            RESP: begin
               state       <= IDLE;
               rsp_valid   <= 1'b0;
               rsp_err     <= 1'b0;
               rsp_timeout <= 1'b0;
               rsp_rdata   <= '0;
               timeout_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
